// File: rtl/mem_arbiter_if.sv
// Requester/memory-port bundle for mem_arbiter; no logic, no latency.
// slave = arbiter side, master = requesters plus memory store side.
// Flow control is req/gnt per requester; the memory port has no backpressure.
interface mem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          reqA, reqB;
    logic          wrA, wrB;
    logic [AW-1:0] adrA, adrB;
    logic [DW-1:0] dinA, dinB;
    logic          gntA, gntB;
    logic [DW-1:0] doutA, doutB;
    logic          vldA, vldB;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_AB;
    logic [DW-1:0] mem_DB;
    logic [DW-1:0] mem_Q;

    modport slave (
        input  reqA, reqB, wrA, wrB, adrA, adrB, dinA, dinB, mem_Q,
        output gntA, gntB, doutA, doutB, vldA, vldB,
               mem_en, mem_wr, mem_AB, mem_DB
    );

    modport master (
        output reqA, reqB, wrA, wrB, adrA, adrB, dinA, dinB, mem_Q,
        input  gntA, gntB, doutA, doutB, vldA, vldB,
               mem_en, mem_wr, mem_AB, mem_DB
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port store; MEM_ARB_RR_EN selects round-robin ties, else A priority.
// Latency: gnt and memory command 1 cycle after winning edge, read vld 2 cycles after gnt.
// Backpressure: a requester holds req until gnt; it is ineligible on the edge ending its own gnt.
module mem_arbiter (
    input  logic           Clk,
    input  logic           Rst,
    mem_arbiter_if.slave   bus
);
    logic elig_a, elig_b;
    logic pick_a, pick_b;
    logic tag1_vld, tag1_own;
    logic tag2_vld, tag2_own;

    // The gnt term stops a still-held request from being captured twice.
    assign elig_a = bus.reqA & ~bus.gntA;
    assign elig_b = bus.reqB & ~bus.gntB;

`ifdef MEM_ARB_RR_EN
    logic last_b;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            last_b <= 1'b1;
        end else if (pick_a) begin
            last_b <= 1'b0;
        end else if (pick_b) begin
            last_b <= 1'b1;
        end
    end

    assign pick_a = elig_a & (~elig_b | last_b);
`else
    assign pick_a = elig_a;
`endif
    assign pick_b = elig_b & ~pick_a;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bus.gntA   <= 1'b0;
            bus.gntB   <= 1'b0;
            bus.mem_en <= 1'b0;
            bus.mem_wr <= 1'b0;
            bus.mem_AB <= '0;
            bus.mem_DB <= '0;
            tag1_vld   <= 1'b0;
            tag1_own   <= 1'b0;
            tag2_vld   <= 1'b0;
            tag2_own   <= 1'b0;
            bus.vldA   <= 1'b0;
            bus.vldB   <= 1'b0;
            bus.doutA  <= '0;
            bus.doutB  <= '0;
        end else begin
            bus.gntA   <= pick_a;
            bus.gntB   <= pick_b;
            bus.mem_en <= pick_a | pick_b;
            if (pick_a) begin
                bus.mem_wr <= bus.wrA;
                bus.mem_AB <= bus.adrA;
                bus.mem_DB <= bus.dinA;
            end else if (pick_b) begin
                bus.mem_wr <= bus.wrB;
                bus.mem_AB <= bus.adrB;
                bus.mem_DB <= bus.dinB;
            end else begin
                bus.mem_wr <= 1'b0;
            end

            // Owner tag travels alongside the store's one-cycle read latency.
            tag1_vld <= (pick_a & ~bus.wrA) | (pick_b & ~bus.wrB);
            tag1_own <= pick_b;
            tag2_vld <= tag1_vld;
            tag2_own <= tag1_own;

            bus.vldA <= tag2_vld & ~tag2_own;
            bus.vldB <= tag2_vld & tag2_own;
            if (tag2_vld && !tag2_own) begin
                bus.doutA <= bus.mem_Q;
            end
            if (tag2_vld && tag2_own) begin
                bus.doutB <= bus.mem_Q;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction table plus hand sequences, read data checked by a scoreboard.
module tb_mem_arbiter;
    logic Clk = 1'b0;
    logic Rst = 1'b1;

    mem_arbiter_if #(.AW(6), .DW(8)) bus ();

    mem_arbiter dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit         own;
        logic [7:0] dat;
        int         due;
    } sb_t;

    typedef struct {
        bit         who;
        bit         wr;
        logic [5:0] adr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    sb_t        sbq[$];
    sb_t        mon_e;
    vec_t       tab[8];
    logic [7:0] refmem[64];
    logic [7:0] store[64];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         log_en = 1'b0;
    logic [1:0] glog[$];
    logic       enlog[$];

    always @(posedge Clk) cyc++;

    // Single-port store: write committed at the command edge, read data the cycle after.
    always @(posedge Clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wr) store[bus.mem_AB] <= bus.mem_DB;
            else            bus.mem_Q <= store[bus.mem_AB];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            chk("gnt_excl", 32'(bus.gntA & bus.gntB), 0);
            chk("vld_excl", 32'(bus.vldA & bus.vldB), 0);
            if (bus.vldA || bus.vldB) begin
                if (sbq.size() == 0) begin
                    chk("vld_unexp", {bus.vldA, bus.vldB}, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("vld_owner", 32'(bus.vldB), 32'(mon_e.own));
                    chk("rd_data", mon_e.own ? bus.doutB : bus.doutA, mon_e.dat);
                    chk("rd_lat", cyc, mon_e.due);
                end
            end
            if (log_en) begin
                glog.push_back({bus.gntA, bus.gntB});
                enlog.push_back(bus.mem_en);
            end
        end
    end

    task automatic issue(input bit who, input bit wr, input logic [5:0] adr,
                         input logic [7:0] din, input bit use_ref, input logic [7:0] exp);
        int         n = 0;
        logic       g;
        logic [7:0] e;
        if (!who) begin
            bus.reqA = 1'b1; bus.wrA = wr; bus.adrA = adr; bus.dinA = din;
        end else begin
            bus.reqB = 1'b1; bus.wrB = wr; bus.adrB = adr; bus.dinB = din;
        end
        do begin
            @(negedge Clk);
            n++;
            g = who ? bus.gntB : bus.gntA;
        end while (!g && n < 20);
        if (!g) begin
            chk("gnt_timeout", n, 0);
        end else begin
            chk("cmd_en", 32'(bus.mem_en), 1);
            chk("cmd_wr", 32'(bus.mem_wr), 32'(wr));
            chk("cmd_adr", 32'(bus.mem_AB), 32'(adr));
            if (wr) begin
                chk("cmd_din", 32'(bus.mem_DB), 32'(din));
                refmem[adr] = din;
            end else begin
                e = use_ref ? refmem[adr] : exp;
                sbq.push_back('{who, e, cyc + 2});
            end
        end
        if (!who) bus.reqA = 1'b0;
        else      bus.reqB = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        int first;

        tab[0] = '{1'b0, 1'b1, 6'h3F, 8'h5A, 8'h00};
        tab[1] = '{1'b0, 1'b0, 6'h3F, 8'h00, 8'h5A};
        tab[2] = '{1'b0, 1'b1, 6'h00, 8'h11, 8'h00};
        tab[3] = '{1'b0, 1'b1, 6'h01, 8'h22, 8'h00};
        tab[4] = '{1'b1, 1'b0, 6'h3F, 8'h00, 8'h5A};
        tab[5] = '{1'b1, 1'b1, 6'h20, 8'hE7, 8'h00};
        tab[6] = '{1'b0, 1'b0, 6'h20, 8'h00, 8'hE7};
        tab[7] = '{1'b1, 1'b0, 6'h00, 8'h00, 8'h11};

        for (int i = 0; i < 64; i++) begin
            refmem[i] = 8'h00;
            store[i]  = 8'h00;
        end
        bus.mem_Q = 8'h00;
        bus.wrA = 1'b0; bus.wrB = 1'b0;
        bus.dinA = 8'h00; bus.dinB = 8'h00;
        bus.adrA = 6'h15; bus.adrB = 6'h2A;
        bus.reqA = 1'b1; bus.reqB = 1'b1;

        // Reset with both requesters asserting.
        #1 Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_gnt", {bus.gntA, bus.gntB}, 0);
        chk("rst_vld", {bus.vldA, bus.vldB}, 0);
        chk("rst_mem", {bus.mem_en, bus.mem_wr, bus.mem_AB, bus.mem_DB}, 0);
        chk("rst_dout", {bus.doutA, bus.doutB}, 0);
        Rst = 1'b1;
        @(negedge Clk);
        chk("rel_gntA", 32'(bus.gntA), 1);
        chk("rel_gntB", 32'(bus.gntB), 0);
        chk("rel_adr", 32'(bus.mem_AB), 32'h15);
        sbq.push_back('{1'b0, refmem[6'h15], cyc + 2});
        bus.reqA = 1'b0;
        bus.reqB = 1'b0;
        repeat (3) @(negedge Clk);

        // Single-requester transactions.
        for (int i = 0; i < 8; i++) begin
            issue(tab[i].who, tab[i].wr, tab[i].adr, tab[i].din, 1'b0, tab[i].exp);
        end
        repeat (4) @(negedge Clk);

        // Read routing: A and B read back-to-back.
        fork
            issue(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 8'h11);
            issue(1'b1, 1'b0, 6'h01, 8'h00, 1'b0, 8'h22);
        join
        repeat (4) @(negedge Clk);

        // Contention: both requesters present four accesses back-to-back.
        log_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    issue(1'b0, 1'(i), 6'(48 + i), 8'(160 + i), 1'b1, 8'h00);
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    if (j % 2 == 0) issue(1'b1, 1'b1, 6'(56 + j), 8'(176 + j), 1'b1, 8'h00);
                    else            issue(1'b1, 1'b0, 6'(48 + j), 8'h00, 1'b1, 8'h00);
                end
            end
        join
        @(negedge Clk);
        log_en = 1'b0;
        ng = 0;
        first = -1;
        for (int i = 0; i < glog.size(); i++) begin
            if (glog[i] != 2'b00) begin
                if (first < 0) first = i;
                ng++;
            end
        end
        chk("cont_grants", ng, 8);
        if (first >= 0) begin
            for (int i = first + 1; i < first + 8 && i < glog.size(); i++) begin
                chk("cont_alt", 32'(glog[i]), 32'({glog[i-1][0], glog[i-1][1]}));
                chk("cont_en", 32'(enlog[i]), 1);
            end
        end
        repeat (4) @(negedge Clk);

        // Write by B then read by A of the same address on the next cycle.
        fork
            issue(1'b1, 1'b1, 6'h10, 8'hC3, 1'b1, 8'h00);
            begin
                @(negedge Clk);
                issue(1'b0, 1'b0, 6'h10, 8'h00, 1'b0, 8'hC3);
            end
        join
        repeat (4) @(negedge Clk);

        // Reset in the cycle after a B read grant aborts the pending return.
        issue(1'b1, 1'b0, 6'h3F, 8'h00, 1'b1, 8'h00);
        @(negedge Clk);
        Rst = 1'b0;
        sbq.delete();
        @(negedge Clk);
        chk("abort_vld_rst", {bus.vldA, bus.vldB}, 0);
        chk("abort_doutB_rst", 32'(bus.doutB), 0);
        Rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("abort_vldB", 32'(bus.vldB), 0);
        end
        chk("abort_doutB", 32'(bus.doutB), 0);

        repeat (3) @(negedge Clk);
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the shared single-port 64x8 memory store. Requester A (host write/read port) and requester B (readout/scan engine) each issue single-word accesses with a req/gnt handshake. The block registers the winning command onto the memory port and tracks in-flight reads so that read data returns to the correct requester with a valid pulse. It sits between the requesters and the store; the store's own start/forward sequencing is unchanged.

## Interface
- AW, 6, address width (64 words)
- DW, 8, data width
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-low
- reqA / reqB  in  1  access request, held until gnt
- wrA / wrB  in  1  1 = write, 0 = read
- adrA / adrB  in  AW  word address
- dinA / dinB  in  DW  write data
- gntA / gntB  out  1  one-cycle grant pulse, registered
- doutA / doutB  out  DW  read data, registered
- vldA / vldB  out  1  one-cycle read-data-valid pulse
- mem_en  out  1  memory command valid
- mem_wr  out  1  memory write strobe
- mem_AB  out  AW  memory address
- mem_DB  out  DW  memory write data
- mem_Q  in  DW  memory read data, valid the cycle after a read command

## Operation
- Reset (Rst=0, any time): all outputs 0; in-flight read tags cleared (pending vld dropped); last-served pointer = B, so A wins the first tie.
- Each rising edge: eligible requesters = reqX=1 and gntX=0 (a requester is not eligible at the edge ending its own gnt cycle; this prevents double-capture of a held request).
- One eligible: it wins. Both eligible: winner per arbitration policy (see Configuration).
- On win at edge E0: capture wrX/adrX/dinX into mem_wr/mem_AB/mem_DB, set mem_en=1, gntX=1 for the cycle E0–E1; update last-served pointer to X.
- No winner: mem_en=0, mem_wr=0; mem_AB/mem_DB hold last value.
- Read tag pipeline: 2 stages of {valid, owner}; stage 1 loaded at E0 when winner reads; shifted each edge.
- At E2 (stage-2 valid): doutOwner <= mem_Q, vldOwner=1 for E2–E3. doutX holds until next vldX; other requester's dout unchanged.
- Writes produce no vld.
- At most one gnt and one vld asserted per cycle; gntA and gntB never simultaneous.
- Requester must hold req, wr, adr, din stable until it sees gnt; it may drop req or present the next access during the gnt cycle.

## Timing
- Grant latency: gnt in the cycle after the first edge where req is sampled and wins.
- Read latency: vld 2 cycles after gnt (command cycle, memory cycle, return cycle).
- Throughput: memory port 1 access/cycle with both requesters active (alternating); single requester 1 access per 2 cycles.
- Reads of the same address from A and B in successive cycles each return the stored value; a write followed next cycle by a read of the same address returns the new data (store is write-then-read ordered by command cycle).
- Reset mid-read: no vld issued afterward for the aborted access; first command after release at earliest edge with Rst=1 and a request.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on ties; winner = requester not last served.
- Not defined: fixed priority, A always wins ties; B is still guaranteed a slot because A is ineligible at the edge ending its gnt cycle. Last-served pointer not implemented.

## Test plan
- Reset: drive Rst=0 with reqA=reqB=1 -> all outputs 0; release -> gntA first cycle, mem_AB=adrA.
- Single write/read: A writes 0x5A to addr 0x3F, then reads 0x3F -> gntA twice, vldA=1 exactly 2 cycles after second gntA, doutA=0x5A, vldB never asserted.
- Contention: reqA and reqB both held for 8 accesses -> gnt alternates A,B,A,B…; mem_en=1 every cycle; with MEM_ARB_RR_EN and without, no gnt overlap.
- Read routing: A reads addr 0x00 (0x11), B reads addr 0x01 (0x22) back-to-back -> vldA with 0x11 then next cycle vldB with 0x22.
- Reset mid-read: assert Rst=0 the cycle after gntB for a read -> vldB never pulses; doutB=0.
- Write-then-read: B writes 0xC3 to addr 0x10, A reads 0x10 next cycle -> doutA=0xC3.
